// File: rtl/clk_div_ce_multi.sv
// clk_div_ce_multi: multi-channel, runtime-programmable periodic clock-enable
// generator. Each channel emits a one-cycle ce pulse every (div+1) clocks and
// a square wave that toggles on every ce. Divide values are double-buffered
// (shadow -> active at update points) and a shared sync strobe phase-aligns
// all enabled channels.
//
// Handshake: there is no valid/ready flow control. div_wr_i[k] is a
// single-cycle strobe that is always accepted on the edge where it is high;
// pend_o[k] reports that an accepted value is waiting for the next update point.
module clk_div_ce_multi #(
    parameter int                     NCH         = 4,
    parameter int                     DIV_BITS    = 16,
    parameter logic [DIV_BITS-1:0]    DIV_DEFAULT = DIV_BITS'(31)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NCH*DIV_BITS-1:0]   div_i,
    input  logic [NCH-1:0]            div_wr_i,
    input  logic [NCH-1:0]            en_i,
    input  logic                      sync_i,
    output logic [NCH-1:0]            ce_o,
    output logic [NCH-1:0]            tog_o,
    output logic [NCH-1:0]            pend_o
);

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        // Channel run state: IDLE while disabled, RUN once an enabled edge
        // has been seen. START is the single transitional edge IDLE->RUN.
        typedef enum logic [1:0] {
            MODE_IDLE  = 2'd0,
            MODE_START = 2'd1,
            MODE_RUN   = 2'd2
        } mode_t;

        logic                r_run;
        logic                w_run_nx;
        mode_t               w_mode;

        logic [DIV_BITS-1:0] r_cnt;
        logic [DIV_BITS-1:0] r_active;
        logic [DIV_BITS-1:0] r_shadow;
        logic                r_pend;
        logic                r_ce;
        logic                r_tog;

        logic [DIV_BITS-1:0] w_slice;
        logic [DIV_BITS-1:0] w_next_div;
        logic [DIV_BITS-1:0] w_cnt_nx;
        logic [DIV_BITS-1:0] w_active_nx;
        logic [DIV_BITS-1:0] w_shadow_nx;
        logic                w_pend_nx;
        logic                w_ce_nx;
        logic                w_tog_nx;
        logic                w_update;

        assign w_slice = div_i[k*DIV_BITS +: DIV_BITS];

        // State register: remembers whether the channel was enabled last edge.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_run <= 1'b0;
            end else begin
                r_run <= w_run_nx;
            end
        end

        // Next-state: the channel is running on the next edge iff enabled now.
        always_comb begin
            w_run_nx = en_i[k];
        end

        // Mode decode: IDLE when disabled, START on the first enabled edge.
        always_comb begin
            w_mode = MODE_RUN;
            if (!en_i[k]) begin
                w_mode = MODE_IDLE;
            end else if (!r_run) begin
                w_mode = MODE_START;
            end
        end

        // Datapath next values: reload/decrement, pulse, toggle, divide update.
        always_comb begin
            // A same-edge write bypasses the shadow so it can reload immediately.
            w_next_div  = div_wr_i[k] ? w_slice : (r_pend ? r_shadow : r_active);
            w_cnt_nx    = r_cnt;
            w_active_nx = r_active;
            w_shadow_nx = div_wr_i[k] ? w_slice : r_shadow;
            w_pend_nx   = r_pend | div_wr_i[k];
            w_ce_nx     = 1'b0;
            w_tog_nx    = r_tog;
            w_update    = 1'b0;
            case (w_mode)
                MODE_IDLE: begin
                    w_cnt_nx = w_next_div;
                    w_update = 1'b1;
                end
                MODE_START: begin
                    w_cnt_nx = w_next_div;
                    w_tog_nx = 1'b0;
                    w_update = 1'b1;
                end
                default: begin
                    // Sync outranks terminal count on the same edge.
                    if (sync_i) begin
                        w_cnt_nx = w_next_div;
                        w_tog_nx = 1'b0;
                        w_update = 1'b1;
                    end else if (r_cnt == '0) begin
                        w_cnt_nx = w_next_div;
                        w_ce_nx  = 1'b1;
                        w_tog_nx = ~r_tog;
                        w_update = 1'b1;
                    end else begin
                        w_cnt_nx = r_cnt - DIV_BITS'(1);
                    end
                end
            endcase
            // Update point: the pending divide becomes active and pend clears,
            // which also absorbs a write landing on the same edge.
            if (w_update) begin
                w_active_nx = w_next_div;
                w_pend_nx   = 1'b0;
            end
        end

        // Datapath registers.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt    <= DIV_DEFAULT;
                r_active <= DIV_DEFAULT;
                r_shadow <= DIV_DEFAULT;
                r_pend   <= 1'b0;
                r_ce     <= 1'b0;
                r_tog    <= 1'b0;
            end else begin
                r_cnt    <= w_cnt_nx;
                r_active <= w_active_nx;
                r_shadow <= w_shadow_nx;
                r_pend   <= w_pend_nx;
                r_ce     <= w_ce_nx;
                r_tog    <= w_tog_nx;
            end
        end

        assign ce_o[k]   = r_ce;
        assign tog_o[k]  = r_tog;
        assign pend_o[k] = r_pend;
    end

endmodule

// File: tb/tb_clk_div_ce_multi.sv
// Testbench for clk_div_ce_multi: table-driven vectors, hand sequences for the
// multi-cycle corners, and randomized stimulus against a time-scheduled model.
module tb_clk_div_ce_multi;

    localparam int NCH = 4;
    localparam int DB  = 16;
    localparam int DEF = 31;

    // ---------------- clock / reset ----------------
    logic              clk;
    logic              rst;
    logic [NCH*DB-1:0] div_i;
    logic [NCH-1:0]    div_wr_i;
    logic [NCH-1:0]    en_i;
    logic              sync_i;
    logic [NCH-1:0]    ce_o;
    logic [NCH-1:0]    tog_o;
    logic [NCH-1:0]    pend_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    clk_div_ce_multi #(
        .NCH(NCH), .DIV_BITS(DB), .DIV_DEFAULT(DB'(DEF))
    ) dut (
        .clk(clk), .rst(rst), .div_i(div_i), .div_wr_i(div_wr_i),
        .en_i(en_i), .sync_i(sync_i), .ce_o(ce_o), .tog_o(tog_o), .pend_o(pend_o)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int t        = 0;
    logic [11:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, t, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Each running channel holds the absolute cycle of its next ce pulse.
    int          m_active[NCH];
    int          m_shadow[NCH];
    longint      m_next[NCH];
    logic [3:0]  m_pend, m_run, m_ce, m_tog;

    function automatic void model_reset();
        for (int k = 0; k < NCH; k++) begin
            m_active[k] = DEF;
            m_shadow[k] = DEF;
            m_next[k]   = 0;
        end
        m_pend = '0; m_run = '0; m_ce = '0; m_tog = '0;
        exp_q.delete();
    endfunction

    function automatic void model_step(input logic [3:0] wr, input logic [63:0] dv,
                                       input logic [3:0] en, input logic sy);
        t++;
        for (int k = 0; k < NCH; k++) begin
            int val;
            int nd;
            val = int'(dv[k*DB +: DB]);
            nd  = wr[k] ? val : (m_pend[k] ? m_shadow[k] : m_active[k]);
            if (wr[k]) m_shadow[k] = val;
            if (!en[k]) begin
                m_active[k] = nd; m_pend[k] = 1'b0; m_run[k] = 1'b0; m_ce[k] = 1'b0;
            end else if (!m_run[k] || sy) begin
                m_run[k] = 1'b1; m_active[k] = nd; m_pend[k] = 1'b0;
                m_ce[k] = 1'b0; m_tog[k] = 1'b0;
                m_next[k] = longint'(t) + nd + 1;
            end else if (longint'(t) == m_next[k]) begin
                m_ce[k] = 1'b1; m_tog[k] = ~m_tog[k];
                m_active[k] = nd; m_pend[k] = 1'b0;
                m_next[k] = longint'(t) + nd + 1;
            end else begin
                m_ce[k] = 1'b0;
                if (wr[k]) m_pend[k] = 1'b1;
            end
        end
        exp_q.push_back({m_ce, m_tog, m_pend});
    endfunction

    // ---------------- driver tasks ----------------
    function automatic logic [63:0] rep(input logic [15:0] d);
        return {4{d}};
    endfunction

    task automatic step(input logic [3:0] wr, input logic [63:0] dv,
                        input logic [3:0] en, input logic sy);
        logic [11:0] e;
        div_wr_i = wr; div_i = dv; en_i = en; sync_i = sy;
        @(posedge clk);
        model_step(wr, dv, en, sy);
        #1;
        e = exp_q.pop_front();
        chk("model_ce",   32'(ce_o),   32'(e[11:8]));
        chk("model_tog",  32'(tog_o),  32'(e[7:4]));
        chk("model_pend", 32'(pend_o), 32'(e[3:0]));
        div_wr_i = '0; sync_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; div_wr_i = '0; div_i = '0; en_i = '0; sync_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ce",   32'(ce_o),   0);
        chk("rst_tog",  32'(tog_o),  0);
        chk("rst_pend", 32'(pend_o), 0);
        rst = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0]  wr;
        logic [15:0] dv;
        logic [3:0]  en;
        logic        sy;
        logic [3:0]  ce;
        logic [3:0]  tog;
        logic [3:0]  pend;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t mk(input logic [3:0] wr, input logic [15:0] dv, input logic [3:0] en,
                                input logic sy, input logic [3:0] ce, input logic [3:0] tog,
                                input logic [3:0] pend);
        vec_t v;
        v.wr = wr; v.dv = dv; v.en = en; v.sy = sy; v.ce = ce; v.tog = tog; v.pend = pend;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int early;
        int first;
        int gap;
        logic [3:0]  cur_en;
        logic [3:0]  wr;
        logic [63:0] dv;
        logic        sy;

        // Channel 0 only: idle write, start, countdown, pending write,
        // div=0 streaming, sync, idle hold of tog, restart.
        tbl[0]  = mk(4'b0001, 16'd2, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        tbl[1]  = mk(4'b0000, 16'd0, 4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        tbl[2]  = mk(4'b0000, 16'd0, 4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        tbl[3]  = mk(4'b0000, 16'd0, 4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        tbl[4]  = mk(4'b0000, 16'd0, 4'b0001, 1'b0, 4'b0001, 4'b0001, 4'b0000);
        tbl[5]  = mk(4'b0001, 16'd0, 4'b0001, 1'b0, 4'b0000, 4'b0001, 4'b0001);
        tbl[6]  = mk(4'b0000, 16'd0, 4'b0001, 1'b0, 4'b0000, 4'b0001, 4'b0001);
        tbl[7]  = mk(4'b0000, 16'd0, 4'b0001, 1'b0, 4'b0001, 4'b0000, 4'b0000);
        tbl[8]  = mk(4'b0000, 16'd0, 4'b0001, 1'b0, 4'b0001, 4'b0001, 4'b0000);
        tbl[9]  = mk(4'b0000, 16'd0, 4'b0001, 1'b1, 4'b0000, 4'b0000, 4'b0000);
        tbl[10] = mk(4'b0000, 16'd0, 4'b0001, 1'b0, 4'b0001, 4'b0001, 4'b0000);
        tbl[11] = mk(4'b0000, 16'd0, 4'b0000, 1'b0, 4'b0000, 4'b0001, 4'b0000);
        tbl[12] = mk(4'b0001, 16'd3, 4'b0000, 1'b0, 4'b0000, 4'b0001, 4'b0000);
        tbl[13] = mk(4'b0000, 16'd0, 4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0000);

        rst = 1'b1; div_wr_i = '0; div_i = '0; en_i = '0; sync_i = 1'b0;
        #2;
        chk("async_rst_ce", 32'(ce_o), 0);
        do_reset();

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].wr, rep(tbl[i].dv), tbl[i].en, tbl[i].sy);
            chk($sformatf("tbl%0d_ce", i),   32'(ce_o),   32'(tbl[i].ce));
            chk($sformatf("tbl%0d_tog", i),  32'(tog_o),  32'(tbl[i].tog));
            chk($sformatf("tbl%0d_pend", i), 32'(pend_o), 32'(tbl[i].pend));
        end

        // Default divide: first ce 32 edges after sync, then every 32.
        do_reset();
        step('0, '0, 4'b0001, 1'b0);
        step('0, '0, 4'b0001, 1'b1);
        early = 0;
        for (int i = 1; i <= 32; i++) begin
            step('0, '0, 4'b0001, 1'b0);
            if (i < 32 && ce_o[0]) early++;
            if (i == 32) chk("default_first_ce", 32'(ce_o), 32'h1);
        end
        chk("default_no_early_ce", early, 0);
        early = 0;
        for (int i = 33; i <= 96; i++) begin
            step('0, '0, 4'b0001, 1'b0);
            if (ce_o[0]) early++;
        end
        chk("default_pulse_count", early, 2);
        chk("default_tog", 32'(tog_o), 32'h1);

        // Mid-period write on ch1: old period completes, then period 5.
        step('0, '0, 4'b0011, 1'b0);
        for (int s = 1; s <= 9; s++) step('0, '0, 4'b0011, 1'b0);
        step(4'b0010, rep(16'd4), 4'b0011, 1'b0);
        chk("ch1_pend_set", 32'(pend_o[1]), 1);
        first = -1;
        for (int s = 11; s <= 45; s++) begin
            step('0, '0, 4'b0011, 1'b0);
            if (ce_o[1]) begin first = s; break; end
        end
        chk("ch1_old_period", first, 32);
        chk("ch1_pend_clear", 32'(pend_o[1]), 0);
        gap = -1;
        for (int j = 1; j <= 10; j++) begin
            step('0, '0, 4'b0011, 1'b0);
            if (ce_o[1]) begin gap = j; break; end
        end
        chk("ch1_new_period", gap, 5);

        // Divides 2,3,5,7 aligned by sync.
        step(4'b1111, {16'd7, 16'd5, 16'd3, 16'd2}, 4'b0000, 1'b0);
        step('0, '0, 4'b1111, 1'b0);
        step('0, '0, 4'b1111, 1'b1);
        chk("sync_edge_ce", 32'(ce_o), 0);
        for (int i = 1; i <= 840; i++) begin
            step('0, '0, 4'b1111, 1'b0);
            if (i == 1)   chk("mix_e1",   32'(ce_o), 32'h0);
            if (i == 3)   chk("mix_e3",   32'(ce_o), 32'h1);
            if (i == 4)   chk("mix_e4",   32'(ce_o), 32'h2);
            if (i == 6)   chk("mix_e6",   32'(ce_o), 32'h5);
            if (i == 8)   chk("mix_e8",   32'(ce_o), 32'hA);
            if (i == 24)  chk("mix_e24",  32'(ce_o), 32'hF);
            if (i == 840) chk("mix_e840", 32'(ce_o), 32'hF);
        end

        // Write on terminal-count edge, en drop, sync while disabled, re-enable.
        step(4'b0100, rep(16'd3), 4'b0000, 1'b0);
        step('0, '0, 4'b0100, 1'b0);
        for (int s = 1; s <= 3; s++) step('0, '0, 4'b0100, 1'b0);
        step(4'b0100, rep(16'd1), 4'b0100, 1'b0);
        chk("tc_write_ce",   32'(ce_o[2]),   1);
        chk("tc_write_pend", 32'(pend_o[2]), 0);
        step('0, '0, 4'b0100, 1'b0);
        chk("tc_write_e5", 32'(ce_o[2]), 0);
        step('0, '0, 4'b0100, 1'b0);
        chk("tc_write_e6", 32'(ce_o[2]), 1);
        step('0, '0, 4'b0000, 1'b0);
        step('0, '0, 4'b0000, 1'b1);
        chk("sync_disabled", 32'(ce_o), 0);
        step('0, '0, 4'b0000, 1'b0);
        step('0, '0, 4'b0100, 1'b0);
        step('0, '0, 4'b0100, 1'b0);
        chk("reen_e1", 32'(ce_o[2]), 0);
        step('0, '0, 4'b0100, 1'b0);
        chk("reen_e2", 32'(ce_o[2]), 1);

        // Randomized traffic against the model.
        cur_en = 4'b1111;
        for (int i = 0; i < 3000; i++) begin
            wr = '0;
            dv = '0;
            for (int k = 0; k < NCH; k++) begin
                if ($urandom_range(0, 15) == 0) wr[k] = 1'b1;
                if ($urandom_range(0, 63) == 0) cur_en[k] = ~cur_en[k];
                if ($urandom_range(0, 40) == 0) dv[k*DB +: DB] = 16'hFFFF;
                else dv[k*DB +: DB] = 16'($urandom_range(0, 9));
            end
            sy = ($urandom_range(0, 49) == 0);
            step(wr, dv, cur_en, sy);
        end

        // Async reset mid-period: outputs drop immediately, default period after.
        step('0, '0, 4'b1111, 1'b0);
        step(4'b1111, rep(16'd5), 4'b1111, 1'b0);
        step('0, '0, 4'b1111, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_ce",   32'(ce_o),   0);
        chk("midrst_tog",  32'(tog_o),  0);
        chk("midrst_pend", 32'(pend_o), 0);
        #1;
        rst = 1'b0;
        model_reset();
        step('0, '0, 4'b1111, 1'b0);
        early = 0;
        for (int i = 1; i <= 40; i++) begin
            step('0, '0, 4'b1111, 1'b0);
            if (i < 32 && ce_o != 0) early++;
            if (i == 32) chk("postrst_first_ce", 32'(ce_o), 32'hF);
        end
        chk("postrst_no_early_ce", early, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
